// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore FSM plus condition/flag logic.
// Define MC_STALL_EN to add MemReady and hold FETCH/MEMRD/MEMWR until it rises.
module arm_mc_controller #(
  parameter logic [3:0] FLAGS_RST = 4'b0000,
  parameter int         ALUCTL_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          Cond,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          ALUFlags,
`ifdef MC_STALL_EN
  input  logic                MemReady,
`endif
  output logic                PCWrite,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic [1:0]          RegSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [3:0]          StateDbg
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, MEMADR, MEMRD, MEMWB,
    MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [ALUCTL_W-1:0] A_ADD = ALUCTL_W'(0);
  localparam logic [ALUCTL_W-1:0] A_SUB = ALUCTL_W'(1);
  localparam logic [ALUCTL_W-1:0] A_AND = ALUCTL_W'(2);
  localparam logic [ALUCTL_W-1:0] A_ORR = ALUCTL_W'(3);

  state_t state, nextState;
  logic [3:0] flags;
  logic memRdy;
  logic nextPc, irW, regW, memW, branch, aluOp, regSrc0;
  logic noWrite, condEx, pcs;
  logic [1:0] flagW;
  logic [ALUCTL_W-1:0] aluDec;

`ifdef MC_STALL_EN
  assign memRdy = MemReady;
`else
  assign memRdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= FLAGS_RST;
    end else begin
      state <= nextState;
      if (aluOp && condEx) begin
        if (flagW[1]) flags[3:2] <= ALUFlags[3:2];
        if (flagW[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    nextState = state;
    nextPc    = 1'b0;
    irW       = 1'b0;
    regW      = 1'b0;
    memW      = 1'b0;
    branch    = 1'b0;
    aluOp     = 1'b0;
    regSrc0   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 2'd0;
    ResultSrc = 2'd0;
    unique case (state)
      FETCH: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        if (memRdy) begin
          irW       = 1'b1;
          nextPc    = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        regSrc0   = 1'b1;
        unique case (Op)
          2'b01:   nextState = MEMADR;
          2'b00:   nextState = Funct[5] ? EXECI : EXECR;
          2'b10:   nextState = BRANCH;
          2'b11:   nextState = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB   = 2'd1;
        nextState = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (memRdy) nextState = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'd1;
        regW      = 1'b1;
        nextState = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        memW   = 1'b1;
        if (memRdy) nextState = FETCH;
      end
      EXECR: begin
        aluOp     = 1'b1;
        nextState = ALUWB;
      end
      EXECI: begin
        ALUSrcB   = 2'd1;
        aluOp     = 1'b1;
        nextState = ALUWB;
      end
      ALUWB: begin
        regW      = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 2'd2;
        ALUSrcB   = 2'd1;
        ResultSrc = 2'd2;
        branch    = 1'b1;
        nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  always_comb begin
    aluDec = A_ADD;
    unique case (Funct[4:1])
      4'b0100: aluDec = A_ADD;
      4'b0010: aluDec = A_SUB;
      4'b0000: aluDec = A_AND;
      4'b1100: aluDec = A_ORR;
      4'b1010: aluDec = A_SUB;
      default: aluDec = A_ADD;
    endcase
  end

  // CMP only exists for data-processing; memory ops reuse these bits
  assign noWrite = (Op == 2'b00) && (Funct[4:1] == 4'b1010);
  assign flagW   = {Funct[0],
                    Funct[0] & ((aluDec == A_ADD) | (aluDec == A_SUB))};
  assign ALUControl = aluOp ? aluDec : A_ADD;

  always_comb begin
    condEx = 1'b0;
    unique case (Cond)
      4'b0000: condEx = flags[2];
      4'b0001: condEx = ~flags[2];
      4'b0010: condEx = flags[1];
      4'b0011: condEx = ~flags[1];
      4'b0100: condEx = flags[3];
      4'b0101: condEx = ~flags[3];
      4'b0110: condEx = flags[0];
      4'b0111: condEx = ~flags[0];
      4'b1000: condEx = flags[1] & ~flags[2];
      4'b1001: condEx = ~flags[1] | flags[2];
      4'b1010: condEx = flags[3] == flags[0];
      4'b1011: condEx = flags[3] != flags[0];
      4'b1100: condEx = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condEx = flags[2] | (flags[3] != flags[0]);
      4'b1110: condEx = 1'b1;
      4'b1111: condEx = 1'b0;
    endcase
  end

  assign pcs = branch | ((Rd == 4'd15) & regW);

  assign PCWrite  = ~reset & (nextPc | (pcs & condEx));
  assign RegWrite = ~reset & regW & condEx & ~noWrite;
  assign MemWrite = ~reset & memW & condEx;
  assign IRWrite  = ~reset & irW;
  assign RegSrc   = {Op == 2'b01, regSrc0};
  assign ImmSrc   = Op;
  assign StateDbg = state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller with an instruction-level model.
// Stall cases run only when MC_STALL_EN is defined.
module tb_arm_mc_controller;

`ifdef MC_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] Cond = 4'hE;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b001000;
  logic [3:0] Rd = 4'd15;
  logic [3:0] ALUFlags = 4'b0000;
  logic MemReady = 1'b1;
  logic PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [1:0] ALUControl;
  logic [3:0] StateDbg;

  arm_mc_controller dut (
    .clk(clk), .reset(reset),
    .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags),
`ifdef MC_STALL_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .StateDbg(StateDbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0] mFlags = 4'b0000;
  bit chk = 1'b0;
  int eState;
  bit eIRW, ePCW, eRegW, eMemW;
  logic [1:0] eALU;
  logic [31:0] trace;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ARM condition: base test from cond[3:1], inverted by cond[0]
  function automatic bit condOk(input logic [3:0] c,
                                input logic [3:0] f);
    bit n, z, cf, v, b;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  function automatic logic [1:0] aluOf(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'd0;
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
      4'b1010: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      check("state", StateDbg, eState);
      check("IRWrite", IRWrite, eIRW);
      check("PCWrite", PCWrite, ePCW);
      check("RegWrite", RegWrite, eRegW);
      check("MemWrite", MemWrite, eMemW);
      check("ALUControl", ALUControl, eALU);
      trace = {trace[27:0], StateDbg};
    end
  end

  task automatic runInstr(input logic [31:0] ins,
                          input logic [3:0] af,
                          input int fw, input int mw,
                          output int cyc);
    int st[$];
    bit rq[$];
    bit ok, rdy, isCmp;
    int s;
    logic [3:0] cmd;
    Cond = ins[31:28];
    Op = ins[27:26];
    Funct = ins[25:20];
    Rd = ins[15:12];
    ALUFlags = af;
    cmd = ins[24:21];
    isCmp = (ins[27:26] == 2'b00) && (cmd == 4'b1010);
    trace = '0;
    cyc = 0;
    for (int k = 0; k < fw; k++) begin
      st.push_back(0); rq.push_back(1'b0);
    end
    st.push_back(0); rq.push_back(1'b1);
    st.push_back(1); rq.push_back(1'b1);
    case (ins[27:26])
      2'b01: begin
        st.push_back(2); rq.push_back(1'b1);
        s = ins[20] ? 3 : 5;
        for (int k = 0; k < mw; k++) begin
          st.push_back(s); rq.push_back(1'b0);
        end
        st.push_back(s); rq.push_back(1'b1);
        if (ins[20]) begin
          st.push_back(4); rq.push_back(1'b1);
        end
      end
      2'b00: begin
        st.push_back(ins[25] ? 7 : 6); rq.push_back(1'b1);
        st.push_back(8); rq.push_back(1'b1);
      end
      2'b10: begin
        st.push_back(9); rq.push_back(1'b1);
      end
      default: ;
    endcase
    for (int i = 0; i < st.size(); i++) begin
      s = st[i];
      MemReady = rq[i];
      rdy = STALL ? MemReady : 1'b1;
      ok = condOk(Cond, mFlags);
      eState = s;
      eIRW = (s == 0) && rdy;
      ePCW = ((s == 0) && rdy) ||
             (ok && ((s == 9) ||
                     (((s == 8) || (s == 4)) && (Rd == 4'd15))));
      eRegW = ok && (((s == 8) && !isCmp) || (s == 4));
      eMemW = ok && (s == 5);
      eALU = ((s == 6) || (s == 7)) ? aluOf(cmd) : 2'd0;
      chk = 1'b1;
      cyc++;
      @(posedge clk);
      if (((s == 6) || (s == 7)) && ok && ins[20]) begin
        mFlags[3:2] = af[3:2];
        if (aluOf(cmd) <= 2'd1) mFlags[1:0] = af[1:0];
      end
      #1;
    end
    MemReady = 1'b1;
  endtask

  int cyc;

  initial begin
    repeat (3) begin
      @(negedge clk);
      check("rst_state", StateDbg, 0);
      check("rst_irw", IRWrite, 0);
      check("rst_pcw", PCWrite, 0);
      check("rst_regw", RegWrite, 0);
      check("rst_memw", MemWrite, 0);
      @(posedge clk);
    end
    #1 reset = 1'b0;

    runInstr(32'hE0802001, 4'b0000, 0, 0, cyc);
    check("lat_add", cyc, 4);
    check("seq_add", trace[15:0], 16'h0168);

    runInstr(32'hE0512002, 4'b0100, 0, 0, cyc);
    check("flags_subs", mFlags, 4'b0100);

    runInstr(32'h0A000001, 4'b0000, 0, 0, cyc);
    check("lat_b", cyc, 3);
    check("seq_beq", trace[11:0], 12'h019);

    runInstr(32'hE3500005, 4'b1000, 0, 0, cyc);
    check("flags_cmp", mFlags, 4'b1000);
    check("seq_cmp", trace[15:0], 16'h0178);

    runInstr(32'h05801000, 4'b0000, 0, 0, cyc);
    check("lat_str", cyc, 4);
    check("seq_streq", trace[15:0], 16'h0125);

    runInstr(32'hE5801000, 4'b0000, 0, 0, cyc);
    runInstr(32'hE5901000, 4'b0000, 0, 0, cyc);
    check("lat_ldr", cyc, 5);
    check("seq_ldr", trace[19:0], 20'h01234);

    runInstr(32'hEC000000, 4'b0000, 0, 0, cyc);
    check("lat_undef", cyc, 2);
    check("seq_undef", trace[7:0], 8'h01);

    runInstr(32'hE080F001, 4'b0000, 0, 0, cyc);
    runInstr(32'h0080F001, 4'b0000, 0, 0, cyc);
    runInstr(32'hE1912002, 4'b1111, 0, 0, cyc);
    check("flags_orrs", mFlags, 4'b1100);
    runInstr(32'hE0012002, 4'b0000, 0, 0, cyc);
    runInstr(32'hCA000001, 4'b0000, 0, 0, cyc);
    runInstr(32'hBA000001, 4'b0000, 0, 0, cyc);
    runInstr(32'hE0512002, 4'b0100, 0, 0, cyc);

    // abort a store in MEMWR by reset; flags must return to reset value
    chk = 1'b0;
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_st", StateDbg, 5);
    check("abort_memw", MemWrite, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    mFlags = 4'b0000;
    runInstr(32'h0A000001, 4'b0000, 0, 0, cyc);
    check("seq_after_abort", trace[11:0], 12'h019);

    if (STALL) begin
      runInstr(32'hE5901000, 4'b0000, 0, 3, cyc);
      check("lat_ldr_stall", cyc, 8);
      check("seq_ldr_stall", trace, 32'h01233334);
      runInstr(32'hE5801000, 4'b0000, 1, 2, cyc);
      check("seq_str_stall", trace[27:0], 28'h0012555);
    end

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
